pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 core. Watches the decode, execute, memory and writeback stage registers and drives the per-stage stall/bubble controls that sequence the fetch→decode→execute pipeline. It covers load-use hazards, `ret` drain, mispredicted branches and exception freeze. A small state machine holds the multi-cycle `ret` drain and the sticky halt condition.

---
 rtl/y86_pkg.sv | 31 +++
 rtl/pipe_ctrl_stats.sv | 35 +++
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, register "none", pipeline control states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes are kept as plain integers so each block can size them to its own STAT_W.
  localparam int S_AOK = 1;
  localparam int S_HLT = 2;
  localparam int S_ADR = 3;
  localparam int S_INS = 4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RET_DRAIN = 2'd1,
    HALT      = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_stats.sv
// Saturating hazard/stall event counters for pipe_ctrl; counts update one edge after the event.
// No backpressure; counting pauses while frozen (core halted).
module pipe_ctrl_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        lu,
  input  logic        mp,
  input  logic        ret_take,
  input  logic        f_stall,
  output logic [31:0] stat_lu_cycles,
  output logic [31:0] stat_mp_count,
  output logic [31:0] stat_ret_count,
  output logic [31:0] stat_stall_cycles
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_lu_cycles    <= '0;
      stat_mp_count     <= '0;
      stat_ret_count    <= '0;
      stat_stall_cycles <= '0;
    end else if (!freeze) begin
      if (lu && (stat_lu_cycles != '1))
        stat_lu_cycles <= stat_lu_cycles + 32'd1;
      if (mp && (stat_mp_count != '1))
        stat_mp_count <= stat_mp_count + 32'd1;
      if (ret_take && (stat_ret_count != '1))
        stat_ret_count <= stat_ret_count + 32'd1;
      if (f_stall && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline stall/bubble control; Mealy outputs in the hazard cycle, state registered.
// Ret drain and sticky halt held by a small FSM; optional counters under PIPE_CTRL_STATS_EN.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int RET_DRAIN_CYCLES = 3,
  parameter int STAT_W           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_dstM,
  input  logic              e_Cnd,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  output logic              F_stall,
  output logic              D_stall,
  output logic              D_bubble,
  output logic              E_bubble,
  output logic              M_bubble,
  output logic              W_stall,
  output logic              halted,
  output logic              ret_busy
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_lu_cycles,
  output logic [31:0]       stat_mp_count,
  output logic [31:0]       stat_ret_count,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int CNT_W = (RET_DRAIN_CYCLES > 1) ? $clog2(RET_DRAIN_CYCLES) : 1;

  pipe_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu, mp, mex, wex, ret_take;

  assign lu  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != REG_NONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mp  = (E_icode == I_JXX) && !e_Cnd;
  assign mex = (m_stat != STAT_W'(S_AOK));
  assign wex = (W_stat != STAT_W'(S_AOK));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    halted    = 1'b0;
    ret_busy  = 1'b0;
    ret_take  = 1'b0;

    // A writeback exception freezes the core in the same cycle it is seen, from any state.
    if ((state == HALT) || wex) begin
      state_nxt = HALT;
      F_stall   = 1'b1;
      D_bubble  = 1'b1;
      E_bubble  = 1'b1;
      M_bubble  = 1'b1;
      W_stall   = 1'b1;
      halted    = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mp) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
          end else if (lu) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
          end else if (D_icode == I_RET) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            ret_take = 1'b1;
            if (RET_DRAIN_CYCLES > 1) begin
              state_nxt = RET_DRAIN;
              cnt_nxt   = CNT_W'(RET_DRAIN_CYCLES - 1);
            end
          end
        end
        RET_DRAIN: begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
          ret_busy = 1'b1;
          cnt_nxt  = cnt - 1'b1;
          if (cnt <= CNT_W'(1))
            state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end

    M_bubble = M_bubble | mex;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  pipe_ctrl_stats u_stats (
    .clk               (clk),
    .rst_n             (rst_n),
    .freeze            (state == HALT),
    .lu                (lu),
    .mp                (mp),
    .ret_take          (ret_take),
    .f_stall           (F_stall),
    .stat_lu_cycles    (stat_lu_cycles),
    .stat_mp_count     (stat_mp_count),
    .stat_ret_count    (stat_ret_count),
    .stat_stall_cycles (stat_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

  localparam int RDC    = 3;
  localparam int STAT_W = 3;

  // Output vector bit positions: {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,halted,ret_busy}
  localparam logic [7:0] B_F  = 8'h80;
  localparam logic [7:0] B_DS = 8'h40;
  localparam logic [7:0] B_DB = 8'h20;
  localparam logic [7:0] B_EB = 8'h10;
  localparam logic [7:0] B_MB = 8'h08;
  localparam logic [7:0] B_WS = 8'h04;
  localparam logic [7:0] B_H  = 8'h02;
  localparam logic [7:0] B_RB = 8'h01;
  localparam logic [7:0] HALT_OUT = B_F | B_DB | B_EB | B_MB | B_WS | B_H;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        D_icode, d_srcA, d_srcB, E_icode, E_dstM;
  logic              e_Cnd;
  logic [STAT_W-1:0] m_stat, W_stat;
  logic              F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted, ret_busy;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0]       stat_lu_cycles, stat_mp_count, stat_ret_count, stat_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.RET_DRAIN_CYCLES(RDC), .STAT_W(STAT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_Cnd    (e_Cnd),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble),
    .M_bubble (M_bubble),
    .W_stall  (W_stall),
    .halted   (halted),
    .ret_busy (ret_busy)
`ifdef PIPE_CTRL_STATS_EN
    ,
    .stat_lu_cycles    (stat_lu_cycles),
    .stat_mp_count     (stat_mp_count),
    .stat_ret_count    (stat_ret_count),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  function automatic logic [7:0] obs();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted, ret_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd  = 1'b1;
    m_stat  = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (obs() !== 8'h00) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", obs(), 8'h00);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [7:0] exp_v [4];
    exp_v[0] = B_F | B_DS | B_EB;   // MRMOVQ -> srcA
    exp_v[1] = B_F | B_DS | B_EB;   // POPQ -> srcB, repeated hazard stalls again
    exp_v[2] = 8'h00;               // dstM none never matches
    exp_v[3] = 8'h00;               // bubble in execute
    for (int i = 0; i < 4; i++) begin
      set_idle();
      case (i)
        0: begin E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; end
        1: begin E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6; end
        2: begin E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; end
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++; $display("FAIL load_use_%0d got=%h exp=%h", i, obs(), exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_ret_drain();
    logic [7:0] e;
    for (int c = 0; c < 4; c++) begin
      set_idle();
      if (c == 0) D_icode = 4'h9;
      e = (c == 0) ? (B_F | B_DB) : (c < 3) ? (B_F | B_DB | B_RB) : 8'h00;
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL ret_drain_c%0d got=%h exp=%h", c, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_mispredict();
    set_idle();
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    @(negedge clk);
    checks++;
    if (obs() !== (B_DB | B_EB)) begin
      failures++; $display("FAIL mispredict got=%h exp=%h", obs(), B_DB | B_EB);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (obs() !== 8'h00) begin
      failures++; $display("FAIL mispredict_no_drain got=%h exp=%h", obs(), 8'h00);
    end
    tick();
    set_idle();
    E_icode = 4'h7; e_Cnd = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 8'h00) begin
      failures++; $display("FAIL jxx_taken got=%h exp=%h", obs(), 8'h00);
    end
    tick();
  endtask

  task automatic test_lu_then_ret();
    logic [7:0] e;
    set_idle();
    E_icode = 4'hB; E_dstM = 4'h4; D_icode = 4'h9; d_srcA = 4'h4; d_srcB = 4'h4;
    @(negedge clk);
    checks++;
    if (obs() !== (B_F | B_DS | B_EB)) begin
      failures++; $display("FAIL lu_ret_stall got=%h exp=%h", obs(), B_F | B_DS | B_EB);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      set_idle();
      if (c == 0) begin D_icode = 4'h9; d_srcA = 4'h4; d_srcB = 4'h4; end
      e = (c == 0) ? (B_F | B_DB) : (c < 3) ? (B_F | B_DB | B_RB) : 8'h00;
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL lu_ret_drain_c%0d got=%h exp=%h", c, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_exception();
    int bad = 0;
    set_idle();
    m_stat = 3'd3;
    @(negedge clk);
    checks++;
    if (obs() !== B_MB) begin
      failures++; $display("FAIL mem_exc got=%h exp=%h", obs(), B_MB);
    end
    tick();
    set_idle();
    W_stat = 3'd3;
    @(negedge clk);
    checks++;
    if (obs() !== HALT_OUT) begin
      failures++; $display("FAIL wb_exc got=%h exp=%h", obs(), HALT_OUT);
    end
    tick();
    for (int c = 0; c < 20; c++) begin
      set_idle();
      E_icode = 4'(c % 12);
      D_icode = 4'h9;
      @(negedge clk);
      if (obs() !== HALT_OUT) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL halt_sticky got=%0d bad cycles exp=0", bad);
    end
    rst_n = 1'b0;
    set_idle();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== 8'h00) begin
      failures++; $display("FAIL halt_reset got=%h exp=%h", obs(), 8'h00);
    end
    tick();
    // Writeback exception arriving mid-drain takes over immediately.
    set_idle(); D_icode = 4'h9;
    tick();
    set_idle(); W_stat = 3'd4;
    @(negedge clk);
    checks++;
    if (obs() !== HALT_OUT) begin
      failures++; $display("FAIL drain_wex got=%h exp=%h", obs(), HALT_OUT);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (obs() !== HALT_OUT) begin
      failures++; $display("FAIL drain_wex_held got=%h exp=%h", obs(), HALT_OUT);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit         m_halt  = 1'b0;
    int         m_drain = 0;
    int         bad     = 0;
    logic [7:0] e;
    bit         luc, mpc, mexc, wexc;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      D_icode = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
      d_srcA  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      d_srcB  = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: E_icode = 4'h5;
        1: E_icode = 4'hB;
        2: E_icode = 4'h7;
        default: E_icode = 4'($urandom_range(0, 11));
      endcase
      E_dstM = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      e_Cnd  = 1'($urandom_range(0, 1));
      m_stat = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;

      luc  = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
      mpc  = (E_icode == 4'h7) && !e_Cnd;
      mexc = (m_stat != 3'd1);
      wexc = (W_stat != 3'd1);

      e = 8'h00;
      if (m_halt || wexc) begin
        e = HALT_OUT;
        m_halt = 1'b1;
      end else if (m_drain > 0) begin
        e = B_F | B_DB | B_RB;
        m_drain--;
      end else if (mpc) begin
        e = B_DB | B_EB;
      end else if (luc) begin
        e = B_F | B_DS | B_EB;
      end else if (D_icode == 4'h9) begin
        e = B_F | B_DB;
        m_drain = RDC - 1;
      end
      if (mexc) e = e | B_MB;
      if (!rst_n) begin
        m_halt  = 1'b0;
        m_drain = 0;
      end

      @(negedge clk);
      checks++;
      if (obs() !== e) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL random_c%0d got=%h exp=%h", c, obs(), e);
      end
      if (D_stall && D_bubble) begin
        failures++;
        if (bad <= 5) $display("FAIL dstall_dbubble_c%0d got=1 exp=0", c);
      end
      tick();
    end
    do_reset();
  endtask

`ifdef PIPE_CTRL_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_idle();
      case (c)
        0, 2: begin E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; end
        4:    begin E_icode = 4'h7; e_Cnd = 1'b0; end
        6:    D_icode = 4'h9;
        default: ;
      endcase
      tick();
    end
    set_idle();
    @(negedge clk);
    checks++;
    if ({stat_lu_cycles, stat_mp_count, stat_ret_count, stat_stall_cycles} !==
        {32'd2, 32'd1, 32'd1, 32'd5}) begin
      failures++;
      $display("FAIL stats got=%0d/%0d/%0d/%0d exp=2/1/1/5", stat_lu_cycles, stat_mp_count,
               stat_ret_count, stat_stall_cycles);
    end
    tick();
  endtask
`endif

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_ret_drain();
    test_mispredict();
    test_lu_then_ret();
    test_exception();
    test_random();
`ifdef PIPE_CTRL_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
